// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating-counter direction prediction and optional gshare indexing.
// The prediction is registered so it lines up with IF/ID; updates arrive from branch resolution.
module branch_predictor #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic              flush,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int GH_W  = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] WT  = CNT_W'(1 << (CNT_W - 1));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  function automatic logic [PERF_W-1:0] sat_perf(input logic [PERF_W-1:0] p);
    return (&p) ? p : p + PERF_W'(1);
  endfunction

  logic             ent_valid  [ENTRIES];
  logic [TAG_W-1:0] ent_tag    [ENTRIES];
  logic [PC_W-1:0]  ent_target [ENTRIES];
  logic [CNT_W-1:0] ent_cnt    [ENTRIES];

  logic [GH_W-1:0]  ghr;
  logic [GH_W-1:0]  ghr_next;
  logic [IDX_W-1:0] hist;

  logic [IDX_W-1:0] lk_idx_p0;
  logic [TAG_W-1:0] lk_tag_p0;
  logic             lk_hit_p0;
  logic             lk_taken_p0;
  logic [PC_W-1:0]  lk_target_p0;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  logic             hit_p1;
  logic             taken_p1;
  logic [PC_W-1:0]  target_p1;
  logic [PERF_W-1:0] perf_cnt;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  // History is zero-extended into the index; in bimodal mode ghr never leaves 0.
  always_comb begin
    hist = '0;
    if (GHR_W > 0) hist[GH_W-1:0] = ghr;
  end

  assign ghr_next = (ghr << 1) | GH_W'(upd_taken);

  // Stage p0: combinational lookup against the current (pre-update) table
  always_comb begin
    lk_idx_p0    = lookup_pc[IDX_W+1:2] ^ hist;
    lk_tag_p0    = lookup_pc[PC_W-1:IDX_W+2];
    lk_hit_p0    = ent_valid[lk_idx_p0] && (ent_tag[lk_idx_p0] == lk_tag_p0);
    lk_taken_p0  = lk_hit_p0 && ent_cnt[lk_idx_p0][CNT_W-1];
    lk_target_p0 = lk_taken_p0 ? ent_target[lk_idx_p0] : lookup_pc + PC_W'(4);
  end

  always_comb begin
    up_idx = upd_pc[IDX_W+1:2] ^ hist;
    up_tag = upd_pc[PC_W-1:IDX_W+2];
    up_hit = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
  end

  // Stage p1: registered prediction plus table/history/counter commit
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_p1    <= 1'b0;
      taken_p1  <= 1'b0;
      target_p1 <= '0;
      ghr       <= '0;
      perf_cnt  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_tag[i]    <= '0;
        ent_target[i] <= '0;
        ent_cnt[i]    <= WNT;
      end
    end else begin
      if (flush) begin
        hit_p1    <= 1'b0;
        taken_p1  <= 1'b0;
        target_p1 <= '0;
      end else if (lookup_en) begin
        hit_p1    <= lk_hit_p0;
        taken_p1  <= lk_taken_p0;
        target_p1 <= lk_target_p0;
      end

      if (upd_valid) begin
        if (up_hit) begin
          if (upd_taken) begin
            ent_cnt[up_idx]    <= sat_inc(ent_cnt[up_idx]);
            ent_target[up_idx] <= upd_target;
          end else begin
            ent_cnt[up_idx] <= sat_dec(ent_cnt[up_idx]);
          end
        end else if (upd_taken) begin
          ent_valid[up_idx]  <= 1'b1;
          ent_tag[up_idx]    <= up_tag;
          ent_target[up_idx] <= upd_target;
          ent_cnt[up_idx]    <= WT;
        end
        if (GHR_W > 0) ghr <= ghr_next;
        if (upd_mispredict) perf_cnt <= sat_perf(perf_cnt);
      end
    end
  end

  assign pred_hit     = hit_p1;
  assign pred_taken   = taken_p1;
  assign pred_target  = target_p1;
  assign perf_mispred = perf_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share one stimulus stream and are
// compared every cycle against an array-based reference model, plus hand-computed spot checks.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        lookup_en = 1'b0, flush = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_mispredict = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;

  logic        h0, t0, h1, t1;
  logic [31:0] tg0, tg1, perf0;
  logic [3:0]  perf1;

  branch_predictor #(.PC_W(32), .ENTRIES(16), .CNT_W(2), .GHR_W(0), .PERF_W(32)) dut0 (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .flush(flush), .lookup_pc(lookup_pc),
    .pred_hit(h0), .pred_taken(t0), .pred_target(tg0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .perf_mispred(perf0));

  branch_predictor #(.PC_W(32), .ENTRIES(16), .CNT_W(2), .GHR_W(4), .PERF_W(4)) dut1 (
    .clk(clk), .rst(rst), .lookup_en(lookup_en), .flush(flush), .lookup_pc(lookup_pc),
    .pred_hit(h1), .pred_taken(t1), .pred_target(tg1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .perf_mispred(perf1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays, integer counters, index = word index mod 16 xor history.
  bit     mv   [2][16];
  longint mtag [2][16];
  longint mtgt [2][16];
  int     mcnt [2][16];
  int     mghr [2];
  longint mperf[2];
  bit     eh   [2];
  bit     et   [2];
  longint etg  [2];
  longint pmax [2] = '{64'hFFFF_FFFF, 64'd15};
  int     ghw  [2] = '{0, 4};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int e = 0; e < 16; e++) begin
          mv[k][e] = 0; mtag[k][e] = 0; mtgt[k][e] = 0; mcnt[k][e] = 1;
        end
        mghr[k] = 0; mperf[k] = 0; eh[k] = 0; et[k] = 0; etg[k] = 0;
      end else begin
        int  li, ui;
        bit  lh, uh;
        if (flush) begin
          eh[k] = 0; et[k] = 0; etg[k] = 0;
        end else if (lookup_en) begin
          li = ((int'(lookup_pc) >>> 2) & 15) ^ mghr[k];
          lh = mv[k][li] && (mtag[k][li] == longint'(lookup_pc) / 64);
          eh[k]  = lh;
          et[k]  = lh && (mcnt[k][li] >= 2);
          etg[k] = et[k] ? mtgt[k][li] : (longint'(lookup_pc) + 4) % (64'd1 << 32);
        end
        if (upd_valid) begin
          ui = ((int'(upd_pc) >>> 2) & 15) ^ mghr[k];
          uh = mv[k][ui] && (mtag[k][ui] == longint'(upd_pc) / 64);
          if (uh && upd_taken) begin
            if (mcnt[k][ui] < 3) mcnt[k][ui]++;
            mtgt[k][ui] = longint'(upd_target);
          end else if (uh) begin
            if (mcnt[k][ui] > 0) mcnt[k][ui]--;
          end else if (upd_taken) begin
            mv[k][ui] = 1; mtag[k][ui] = longint'(upd_pc) / 64;
            mtgt[k][ui] = longint'(upd_target); mcnt[k][ui] = 2;
          end
          if (ghw[k] > 0) mghr[k] = (mghr[k] * 2 + int'(upd_taken)) % 16;
          if (upd_mispredict && mperf[k] < pmax[k]) mperf[k]++;
        end
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_hit0",    64'(h0),    64'(eh[0]));
      chk("m_taken0",  64'(t0),    64'(et[0]));
      chk("m_target0", 64'(tg0),   etg[0]);
      chk("m_perf0",   64'(perf0), mperf[0]);
      chk("m_hit1",    64'(h1),    64'(eh[1]));
      chk("m_taken1",  64'(t1),    64'(et[1]));
      chk("m_target1", 64'(tg1),   etg[1]);
      chk("m_perf1",   64'(perf1), mperf[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    lookup_en = 0; flush = 0; upd_valid = 0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    set_idle();
    lookup_en = 1; lookup_pc = pc;
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg, input bit mp);
    set_idle();
    upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispredict = mp;
    tick();
  endtask

  function automatic logic [31:0] rpc();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    // Reset
    rst = 1; tick(); tick();
    cmp_en = 1;
    rst = 0;
    chk("rst_hit", 64'(h0), 0);
    chk("rst_target", 64'(tg0), 0);
    chk("rst_perf", 64'(perf0), 0);

    // Cold lookup
    look(32'h100);
    chk("cold_hit", 64'(h0), 0);
    chk("cold_taken", 64'(t0), 0);
    chk("cold_target", 64'(tg0), 64'h104);
    chk("cold_perf", 64'(perf0), 0);

    // Allocate, saturate at 3, one step back to 2
    upd(32'h100, 1, 32'h080, 1);
    look(32'h100);
    chk("alloc_hit", 64'(h0), 1);
    chk("alloc_taken", 64'(t0), 1);
    chk("alloc_target", 64'(tg0), 64'h080);
    chk("alloc_perf", 64'(perf0), 1);
    repeat (3) upd(32'h100, 1, 32'h080, 0);
    upd(32'h100, 0, 32'h0, 0);
    look(32'h100);
    chk("sat_taken", 64'(t0), 1);

    // Back to 3, then two not-taken -> 1 (predict not taken)
    upd(32'h100, 1, 32'h080, 0);
    repeat (2) upd(32'h100, 0, 32'h0, 0);
    look(32'h100);
    chk("dec_hit", 64'(h0), 1);
    chk("dec_taken", 64'(t0), 0);
    chk("dec_target", 64'(tg0), 64'h104);
    // Floor at 0: one taken afterwards must leave it at 1 (not taken)
    repeat (3) upd(32'h100, 0, 32'h0, 0);
    upd(32'h100, 1, 32'h080, 0);
    look(32'h100);
    chk("floor_taken", 64'(t0), 0);
    upd(32'h100, 1, 32'h080, 0);
    look(32'h100);
    chk("floor_recover", 64'(t0), 1);

    // Aliasing on index 0
    look(32'h140);
    chk("alias_miss", 64'(h0), 0);
    upd(32'h140, 0, 32'h0, 0);
    look(32'h100);
    chk("alias_keep_hit", 64'(h0), 1);
    chk("alias_keep_tgt", 64'(tg0), 64'h080);
    upd(32'h140, 1, 32'h200, 0);
    look(32'h140);
    chk("alias_new_hit", 64'(h0), 1);
    chk("alias_new_tgt", 64'(tg0), 64'h200);
    look(32'h100);
    chk("alias_evicted", 64'(h0), 0);

    // Flush beats lookup
    set_idle(); flush = 1; lookup_en = 1; lookup_pc = 32'h140; tick();
    chk("flush_hit", 64'(h0), 0);
    chk("flush_taken", 64'(t0), 0);
    chk("flush_target", 64'(tg0), 0);

    // Stall holds
    look(32'h140);
    set_idle(); lookup_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hit", 64'(h0), 1);
      chk("stall_target", 64'(tg0), 64'h200);
    end

    // Read-before-write on the same entry
    set_idle(); lookup_en = 1; lookup_pc = 32'h300;
    upd_valid = 1; upd_pc = 32'h300; upd_taken = 1; upd_target = 32'h400; tick();
    chk("rbw_hit", 64'(h0), 0);
    look(32'h300);
    chk("rbw_after_hit", 64'(h0), 1);
    chk("rbw_after_tgt", 64'(tg0), 64'h400);

    // Update during flush still commits
    set_idle(); flush = 1;
    upd_valid = 1; upd_pc = 32'h380; upd_taken = 1; upd_target = 32'h500; tick();
    look(32'h380);
    chk("flush_upd_hit", 64'(h0), 1);
    chk("flush_upd_tgt", 64'(tg0), 64'h500);

    // Randomized traffic, including occasional resets
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rst            = ($urandom_range(0, 299) == 0);
      lookup_en      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 9) == 0);
      lookup_pc      = rpc();
      upd_valid      = 1'($urandom_range(0, 1));
      upd_pc         = rpc();
      upd_taken      = 1'($urandom_range(0, 1));
      upd_target     = $urandom;
      upd_mispredict = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle(); rst = 0;

    // Gshare instance from a fresh reset
    rst = 1; tick(); rst = 0;
    set_idle(); upd_mispredict = 1; upd_taken = 1; tick();
    chk("gate_perf1", 64'(perf1), 0);
    chk("gate_perf0", 64'(perf0), 0);
    // History 0000->0001->0011->0110->1101; last T allocates at 0^0xD = 13
    upd(32'h100, 1, 32'h080, 0);
    upd(32'h100, 1, 32'h080, 0);
    upd(32'h100, 0, 32'h080, 0);
    upd(32'h100, 1, 32'h080, 0);
    upd(32'h100, 1, 32'h080, 0);
    // History is now 1011; 0x134 indexes 13^11 = 6, which the 4th update (history 0110) allocated
    look(32'h134);
    chk("gs_134_hit", 64'(h1), 1);
    chk("gs_134_tgt", 64'(tg1), 64'h080);
    look(32'h118);
    chk("gs_idx13_hit", 64'(h1), 1);
    look(32'h100);
    chk("gs_idx11_miss", 64'(h1), 0);
    chk("gs_idx11_tgt", 64'(tg1), 64'h104);

    repeat (20) upd(32'h100, 1, 32'h080, 1);
    chk("perf1_sat", 64'(perf1), 64'd15);
    chk("perf0_cnt", 64'(perf0), 64'd20);

    tick();
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
